// File: rtl/interpreter_tx_scheduler.sv
// Captures processor COM reads into a FIFO and offers them one at a time to the interpreter with a valid/ack handshake.
// Optional ack timeout is enabled by defining INTERP_TIMEOUT_EN.
module interpreter_tx_scheduler #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemtoReg,
   input  logic        COM,
   input  logic [31:0] ReadData,
   input  logic        tx_ack,
   output logic [14:0] tx_data,
   output logic        tx_valid,
   output logic        stall,
   output logic        fifo_empty,
   output logic        overflow,
   output logic        timeout_err,
   output logic [15:0] sent_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state;
   logic [14:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          cap;
   logic          cap_q;
   logic          cap_evt;
   logic          evt_q;
   logic [14:0]   data_q;
   logic          full;
   logic          push;
   logic          pop;
   logic          unused_read_bits;

   assign unused_read_bits = ^ReadData[31:15];

   assign cap        = MemtoReg & COM;
   assign cap_evt    = cap & ~cap_q;
   assign full       = (count == CW'(DEPTH));
   assign push       = evt_q & ~full;
   assign pop        = (state == IDLE) && (count != '0);
   assign stall      = full;
   assign fifo_empty = (count == '0);

   // Edge-detected capture is registered with its data, so the FIFO write lands one edge after the sampling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q    <= 1'b0;
         evt_q    <= 1'b0;
         data_q   <= '0;
         overflow <= 1'b0;
      end else begin
         cap_q <= cap;
         evt_q <= cap_evt;
         if (cap_evt)
            data_q <= ReadData[14:0];
         if (evt_q && full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef INTERP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer;
`else
   assign timeout_err = 1'b0;
`endif

   // Handshake FSM; GAP guarantees two low cycles between consecutive offers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         sent_count <= '0;
`ifdef INTERP_TIMEOUT_EN
         timer       <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data  <= mem[rd_ptr];
                  tx_valid <= 1'b1;
                  state    <= SEND;
`ifdef INTERP_TIMEOUT_EN
                  timer <= '0;
`endif
               end
            end
            SEND: begin
               if (tx_ack) begin
                  tx_valid   <= 1'b0;
                  sent_count <= sent_count + 16'd1;
                  state      <= GAP;
               end
`ifdef INTERP_TIMEOUT_EN
               else if (timer == TW'(TIMEOUT - 1)) begin
                  tx_valid    <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= GAP;
               end else begin
                  timer <= timer + 1'b1;
               end
`endif
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interpreter_tx_scheduler.sv
// Directed self-checking bench for interpreter_tx_scheduler (DEPTH=8).
module tb_interpreter_tx_scheduler;

`ifdef INTERP_TIMEOUT_EN
   localparam int TB_TIMEOUT = 10;
`else
   localparam int TB_TIMEOUT = 1000;
`endif

   logic        clk;
   logic        reset;
   logic        MemtoReg;
   logic        COM;
   logic [31:0] ReadData;
   logic        tx_ack;
   logic [14:0] tx_data;
   logic        tx_valid;
   logic        stall;
   logic        fifo_empty;
   logic        overflow;
   logic        timeout_err;
   logic [15:0] sent_count;

   int vectors     = 0;
   int miscompares = 0;
   int exp_sent    = 0;

   interpreter_tx_scheduler #(.DEPTH(8), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .MemtoReg(MemtoReg), .COM(COM), .ReadData(ReadData),
      .tx_ack(tx_ack), .tx_data(tx_data), .tx_valid(tx_valid), .stall(stall),
      .fifo_empty(fifo_empty), .overflow(overflow), .timeout_err(timeout_err),
      .sent_count(sent_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic read_word(input logic [31:0] d);
      MemtoReg = 1'b1;
      COM      = 1'b1;
      ReadData = d;
      tick;
      MemtoReg = 1'b0;
      tick;
   endtask

   task automatic idle_cycles(input int n);
      tx_ack   = 1'b0;
      MemtoReg = 1'b0;
      for (int i = 0; i < n; i++) tick;
   endtask

   task automatic test_reset;
      #2;
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
      vectors++; if (tx_data !== 15'h0) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 0000", tx_data); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
      vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_fifo_empty: got %b expected 1", fifo_empty); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      vectors++; if (sent_count !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_sent_count: got %h expected 0000", sent_count); end
      #10;
      reset = 1'b1;
      idle_cycles(3);
   endtask

   task automatic test_single_word;
      idle_cycles(3);
      MemtoReg = 1'b1;
      COM      = 1'b1;
      ReadData = 32'h0001_2345;
      tick;
      MemtoReg = 1'b0;
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_valid_e0: got %b expected 0", tx_valid); end
      tick;
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_valid_e1: got %b expected 0", tx_valid); end
      vectors++; if (fifo_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL single_queued: got %b expected 0", fifo_empty); end
      tick;
      vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid_e2: got %b expected 1", tx_valid); end
      vectors++; if (tx_data !== 15'h2345) begin miscompares++; $display("[TB] FAIL single_data: got %h expected 2345", tx_data); end
      for (int i = 0; i < 3; i++) tick;
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 15'h2345) begin miscompares++; $display("[TB] FAIL single_hold: got valid %b data %h expected 1 2345", tx_valid, tx_data); end
      tx_ack = 1'b1;
      tick;
      tx_ack = 1'b0;
      exp_sent++;
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ack_valid: got %b expected 0", tx_valid); end
      vectors++; if (sent_count !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL single_sent: got %0d expected %0d", sent_count, exp_sent); end
      vectors++; if (fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL single_empty: got %b expected 1", fifo_empty); end
   endtask

   task automatic test_back_to_back;
      logic [14:0] got [3];
      int          gaps [3];
      logic [14:0] want [3];
      int          npulse;
      int          lowrun;
      logic        prev;
      want   = '{15'h0011, 15'h0022, 15'h0033};
      got    = '{15'h0, 15'h0, 15'h0};
      gaps   = '{0, 0, 0};
      npulse = 0;
      lowrun = 0;
      prev   = 1'b0;
      idle_cycles(3);
      tx_ack = 1'b1;
      for (int i = 0; i < 30; i++) begin
         MemtoReg = (i == 0 || i == 2 || i == 4);
         COM      = 1'b1;
         ReadData = (i == 0) ? 32'h0011 : (i == 2) ? 32'h0022 : 32'h0033;
         tick;
         if (tx_valid && !prev) begin
            if (npulse < 3) begin
               got[npulse]  = tx_data;
               gaps[npulse] = lowrun;
            end
            npulse++;
         end
         lowrun = tx_valid ? 0 : lowrun + 1;
         prev   = tx_valid;
      end
      MemtoReg = 1'b0;
      tx_ack   = 1'b0;
      exp_sent += 3;
      vectors++; if (npulse !== 3) begin miscompares++; $display("[TB] FAIL burst_pulses: got %0d expected 3", npulse); end
      for (int k = 0; k < 3; k++) begin
         vectors++; if (got[k] !== want[k]) begin miscompares++; $display("[TB] FAIL burst_data%0d: got %h expected %h", k, got[k], want[k]); end
      end
      for (int k = 1; k < 3; k++) begin
         vectors++; if (gaps[k] !== 2) begin miscompares++; $display("[TB] FAIL burst_gap%0d: got %0d expected 2", k, gaps[k]); end
      end
      vectors++; if (sent_count !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL burst_sent: got %0d expected %0d", sent_count, exp_sent); end
   endtask

   // The first read is popped straight into SEND, so nine reads fill the 8-deep FIFO and the tenth is the one dropped.
   task automatic test_full_overflow;
      logic [14:0] got [16];
      int          n;
      idle_cycles(3);
      for (int k = 0; k < 9; k++) begin
         read_word(32'h0000_0100 + 32'(k));
         if (k == 7) begin
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL full_stall_7: got %b expected 0", stall); end
         end
      end
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL full_stall: got %b expected 1", stall); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_no_overflow: got %b expected 0", overflow); end
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 15'h0100) begin miscompares++; $display("[TB] FAIL full_inflight: got valid %b data %h expected 1 0100", tx_valid, tx_data); end
      read_word(32'h0000_0109);
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL full_overflow: got %b expected 1", overflow); end
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL full_stall_after_drop: got %b expected 1", stall); end
      n = 0;
      tx_ack = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (tx_valid) begin
            if (n < 16) got[n] = tx_data;
            n++;
         end
         tick;
      end
      tx_ack = 1'b0;
      exp_sent += 9;
      vectors++; if (n !== 9) begin miscompares++; $display("[TB] FAIL drain_count: got %0d expected 9", n); end
      for (int k = 0; k < 9 && k < n; k++) begin
         vectors++; if (got[k] !== 15'(32'h0100 + 32'(k))) begin miscompares++; $display("[TB] FAIL drain_data%0d: got %h expected %h", k, got[k], 15'(32'h0100 + 32'(k))); end
      end
      vectors++; if (sent_count !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL drain_sent: got %0d expected %0d", sent_count, exp_sent); end
      vectors++; if (overflow !== 1'b1 || stall !== 1'b0 || fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_flags: got ovf %b stall %b empty %b expected 1 0 1", overflow, stall, fifo_empty); end
   endtask

   task automatic test_strobe_width;
      logic [14:0] first;
      int          n;
      first = 15'h0;
      n     = 0;
      idle_cycles(3);
      tx_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         MemtoReg = (i < 5) || (i == 10);
         COM      = (i != 10);
         ReadData = 32'h1234_A000 + 32'(i);
         if (tx_valid) begin
            if (n == 0) first = tx_data;
            n++;
         end
         tick;
      end
      MemtoReg = 1'b0;
      COM      = 1'b1;
      tx_ack   = 1'b0;
      exp_sent++;
      vectors++; if (n !== 1) begin miscompares++; $display("[TB] FAIL strobe_count: got %0d expected 1", n); end
      vectors++; if (first !== 15'h2000) begin miscompares++; $display("[TB] FAIL strobe_data: got %h expected 2000", first); end
      vectors++; if (sent_count !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL strobe_sent: got %0d expected %0d", sent_count, exp_sent); end
   endtask

   task automatic test_timeout;
      int n;
      idle_cycles(3);
      read_word(32'h0000_0701);
      for (int i = 0; i < 5 && !tx_valid; i++) tick;
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 15'h0701) begin miscompares++; $display("[TB] FAIL timeout_offer: got valid %b data %h expected 1 0701", tx_valid, tx_data); end
      n = 1;
      for (int i = 0; i < TB_TIMEOUT && tx_valid; i++) begin
         MemtoReg = (i == 0);
         COM      = 1'b1;
         ReadData = 32'h0000_0702;
         tick;
         if (tx_valid) n++;
      end
      MemtoReg = 1'b0;
`ifdef INTERP_TIMEOUT_EN
      vectors++; if (n !== 10) begin miscompares++; $display("[TB] FAIL timeout_high_cycles: got %0d expected 10", n); end
      vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got %b expected 1", timeout_err); end
`else
      vectors++; if (n !== TB_TIMEOUT + 1) begin miscompares++; $display("[TB] FAIL timeout_high_cycles: got %0d expected %0d", n, TB_TIMEOUT + 1); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_err: got %b expected 0", timeout_err); end
      tx_ack = 1'b1;
      tick;
      tx_ack = 1'b0;
      exp_sent++;
`endif
      for (int i = 0; i < 10 && !tx_valid; i++) tick;
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 15'h0702) begin miscompares++; $display("[TB] FAIL timeout_next: got valid %b data %h expected 1 0702", tx_valid, tx_data); end
      tx_ack = 1'b1;
      tick;
      tx_ack = 1'b0;
      exp_sent++;
      vectors++; if (sent_count !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL timeout_sent: got %0d expected %0d", sent_count, exp_sent); end
   endtask

   task automatic test_reset_mid_send;
      idle_cycles(3);
      for (int k = 0; k < 5; k++) read_word(32'h0000_0200 + 32'(k));
      vectors++; if (tx_valid !== 1'b1 || fifo_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL midsend_setup: got valid %b empty %b expected 1 0", tx_valid, fifo_empty); end
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midsend_valid: got %b expected 0", tx_valid); end
      vectors++; if (fifo_empty !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("[TB] FAIL midsend_fifo: got empty %b stall %b expected 1 0", fifo_empty, stall); end
      vectors++; if (sent_count !== 16'h0) begin miscompares++; $display("[TB] FAIL midsend_sent: got %0d expected 0", sent_count); end
      vectors++; if (overflow !== 1'b0 || tx_data !== 15'h0) begin miscompares++; $display("[TB] FAIL midsend_clear: got ovf %b data %h expected 0 0000", overflow, tx_data); end
      exp_sent = 0;
      MemtoReg = 1'b1;
      COM      = 1'b1;
      ReadData = 32'h0000_0555;
      tick;
      tick;
      reset = 1'b1;
      tick;
      vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL release_valid_e0: got %b expected 0", tx_valid); end
      tick;
      vectors++; if (tx_valid !== 1'b0 || fifo_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL release_e1: got valid %b empty %b expected 0 0", tx_valid, fifo_empty); end
      tick;
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 15'h0555) begin miscompares++; $display("[TB] FAIL release_e2: got valid %b data %h expected 1 0555", tx_valid, tx_data); end
      MemtoReg = 1'b0;
      tx_ack   = 1'b1;
      tick;
      tx_ack   = 1'b0;
      exp_sent++;
      for (int i = 0; i < 5; i++) tick;
      vectors++; if (sent_count !== 16'(exp_sent) || tx_valid !== 1'b0 || fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL release_final: got sent %0d valid %b empty %b expected %0d 0 1", sent_count, tx_valid, fifo_empty, exp_sent); end
   endtask

   initial begin
      reset    = 1'b0;
      MemtoReg = 1'b0;
      COM      = 1'b0;
      ReadData = 32'h0;
      tx_ack   = 1'b0;
      test_reset;
      test_single_word;
      test_back_to_back;
      test_full_overflow;
      test_strobe_width;
      test_timeout;
      test_reset_mid_send;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
